// File: rtl/mem_access_unit.sv
// CPU-side load/store unit for the 0x3000..0x3FFF data memory window.
// Sub-word stores are read-modify-write; misaligned or out-of-window requests get an error response.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] buf_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    assign req_bad = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_addr[31:12] != 20'h00003);

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (size_q)
            2'b00:   load_val = {{24{sgn_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{sgn_q & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase

        // Splice the store data into the freshly read word at the byte offset.
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = buf_q[7:0];
                2'd1: merged[15:8]  = buf_q[7:0];
                2'd2: merged[23:16] = buf_q[7:0];
                2'd3: merged[31:24] = buf_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = buf_q[15:0];
        end else begin
            merged[15:0] = buf_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)                         state_nx = RESP;
                    else if (req_we && req_size == 2'b10) state_nx = WRITE;
                    else                                 state_nx = READ;
                end
            end
            READ: begin
                mem_addr = {addr_q[31:2], 2'b00};
                state_nx = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_we    = 1'b1;
                mem_wdata = buf_q;
                state_nx  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= 32'h0;
            buf_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                buf_q   <= req_wdata;
                rdata_q <= 32'h0;
                err_q   <= req_bad;
            end
        end else if (state == READ) begin
            if (we_q) buf_q   <= merged;
            else      rdata_q <= load_val;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: latency, data extraction/merge, errors, backpressure, reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    // Results of the last run_req call
    int          lat, pulses, pcyc;
    logic [31:0] got_rdata, paddr, pdata;
    logic        got_err;

    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (pre_en) mem[1023] <= 32'h8899AABB;
        else if (mem_we && mem_addr[31:12] == 20'h00003) mem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic preload();
        @(negedge clk); pre_en = 1'b1;
        @(posedge clk); #1 pre_en = 1'b0;
    endtask

    // Issue one request and wait (bounded) for resp_valid; records latency and any mem_we pulses.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_signed = ~sgn;
        req_addr = 32'h3000; req_wdata = 32'hDEADBEEF;
        cyc = 1; lat = 0; pulses = 0; pcyc = 0; paddr = 0; pdata = 0;
        got_rdata = 32'h0; got_err = 1'b0;
        while (lat == 0 && cyc < 20) begin
            @(negedge clk);
            if (mem_we) begin pulses++; pcyc = cyc; paddr = mem_addr; pdata = mem_wdata; end
            if (resp_valid) begin
                lat = cyc; got_rdata = resp_rdata; got_err = resp_err;
            end else begin
                @(posedge clk); cyc++;
            end
        end
        checks++;
        if (lat == 0) begin errors++; $display("FAIL timeout: no resp_valid within %0d cycles", cyc); end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL post_handshake: resp_valid=%b req_ready=%b, want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: ready=%b valid=%b err=%b we=%b, want all 0",
                               req_ready, resp_valid, resp_err, mem_we);
        end
        checks++;
        if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, want 0", resp_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release: req_ready=%b want 1", req_ready); end
    endtask

    task automatic test_byte_load();
        preload();
        run_req(1'b0, 2'b00, 1'b1, 32'h3FFD, 32'h0);
        checks++;
        if (got_rdata !== 32'hFFFFFFAA || got_err !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL sbyte_load: rdata=%h err=%b lat=%0d, want ffffffaa/0/2", got_rdata, got_err, lat);
        end
        finish_resp();
        run_req(1'b0, 2'b00, 1'b0, 32'h3FFD, 32'h0);
        checks++;
        if (got_rdata !== 32'h000000AA || got_err !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL ubyte_load: rdata=%h err=%b lat=%0d, want 000000aa/0/2", got_rdata, got_err, lat);
        end
        finish_resp();
        run_req(1'b0, 2'b01, 1'b1, 32'h3FFE, 32'h0);
        checks++;
        if (got_rdata !== 32'hFFFF8899 || lat != 2) begin
            errors++; $display("FAIL shalf_load: rdata=%h lat=%0d, want ffff8899/2", got_rdata, lat);
        end
        finish_resp();
    endtask

    task automatic test_half_store();
        preload();
        run_req(1'b1, 2'b01, 1'b0, 32'h3FFE, 32'h00001234);
        checks++;
        if (pulses != 1 || pcyc != 2 || paddr !== 32'h3FFC || pdata !== 32'h1234AABB) begin
            errors++; $display("FAIL half_store_mem: pulses=%0d cyc=%0d addr=%h data=%h, want 1/2/3ffc/1234aabb",
                               pulses, pcyc, paddr, pdata);
        end
        checks++;
        if (lat != 3 || got_rdata !== 32'h0 || got_err !== 1'b0) begin
            errors++; $display("FAIL half_store_resp: lat=%0d rdata=%h err=%b, want 3/0/0", lat, got_rdata, got_err);
        end
        finish_resp();
        checks++;
        if (mem[1023] !== 32'h1234AABB) begin
            errors++; $display("FAIL half_store_word: mem=%h want 1234aabb", mem[1023]);
        end
    endtask

    task automatic test_word_ops();
        preload();
        run_req(1'b1, 2'b10, 1'b0, 32'h3000, 32'hCAFEF00D);
        checks++;
        if (lat != 2 || pulses != 1 || pcyc != 1 || paddr !== 32'h3000 || pdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL word_store: lat=%0d pulses=%0d cyc=%0d addr=%h data=%h, want 2/1/1/3000/cafef00d",
                               lat, pulses, pcyc, paddr, pdata);
        end
        finish_resp();
        run_req(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
        checks++;
        if (got_rdata !== 32'hCAFEF00D || lat != 2) begin
            errors++; $display("FAIL word_load: rdata=%h lat=%0d, want cafef00d/2", got_rdata, lat);
        end
        finish_resp();
    endtask

    task automatic test_errors();
        preload();
        run_req(1'b0, 2'b10, 1'b0, 32'h3FFA, 32'h0);
        checks++;
        if (got_err !== 1'b1 || got_rdata !== 32'h0 || lat != 1 || pulses != 0) begin
            errors++; $display("FAIL misaligned_load: err=%b rdata=%h lat=%0d pulses=%0d, want 1/0/1/0",
                               got_err, got_rdata, lat, pulses);
        end
        finish_resp();
        run_req(1'b1, 2'b10, 1'b0, 32'h4000, 32'h11223344);
        checks++;
        if (got_err !== 1'b1 || lat != 1 || pulses != 0) begin
            errors++; $display("FAIL window_store: err=%b lat=%0d pulses=%0d, want 1/1/0", got_err, lat, pulses);
        end
        finish_resp();
        checks++;
        if (mem[1023] !== 32'h8899AABB) begin
            errors++; $display("FAIL window_store_mem: mem=%h want 8899aabb", mem[1023]);
        end
        run_req(1'b0, 2'b11, 1'b0, 32'h3FFC, 32'h0);
        checks++;
        if (got_err !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL illegal_size: err=%b lat=%0d, want 1/1", got_err, lat);
        end
        finish_resp();
        run_req(1'b1, 2'b01, 1'b0, 32'h3FFD, 32'hFFFF);
        checks++;
        if (got_err !== 1'b1 || pulses != 0) begin
            errors++; $display("FAIL odd_half_store: err=%b pulses=%0d, want 1/0", got_err, pulses);
        end
        finish_resp();
    endtask

    task automatic test_backpressure();
        preload();
        run_req(1'b0, 2'b10, 1'b1, 32'h3FFC, 32'h0);
        checks++;
        if (got_rdata !== 32'h8899AABB || lat != 2) begin
            errors++; $display("FAIL hold_first: rdata=%h lat=%0d, want 8899aabb/2", got_rdata, lat);
        end
        // A competing request during the stall must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h3FFC; req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899AABB || req_ready !== 1'b0 || mem_we !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d: valid=%b rdata=%h ready=%b we=%b, want 1/8899aabb/0/0",
                                   i, resp_valid, resp_rdata, req_ready, mem_we);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem[1023] !== 32'h8899AABB) begin
            errors++; $display("FAIL hold_release: ready=%b valid=%b mem=%h, want 1/0/8899aabb",
                               req_ready, resp_valid, mem[1023]);
        end
    endtask

    task automatic test_reset_in_write();
        preload();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h3FFC; req_wdata = 32'h00000055;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_write_enter: mem_we=%b want 1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_write_drop: we=%b ready=%b valid=%b wdata=%h, want 0/0/0/0",
                               mem_we, req_ready, resp_valid, mem_wdata);
        end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem[1023] !== 32'h8899AABB) begin
            errors++; $display("FAIL rst_write_after: ready=%b valid=%b mem=%h, want 1/0/8899aabb",
                               req_ready, resp_valid, mem[1023]);
        end
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_half_store();
        test_word_ops();
        test_errors();
        test_backpressure();
        test_reset_in_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  block accepts a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response valid.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  request rejected.
- mem_addr  out  32  word-aligned byte address to data memory (bits [1:0] = 00).
- mem_we  out  1  data memory write enable, sampled on rising clk.
- mem_wdata  out  32  data memory write data.
- mem_rdata  in  32  data memory read data; combinational from mem_addr in the same cycle.

Function
REQ-002 Data memory window SHALL be 0x3000..0x3FFF (1024 words, top word 0x3FFC); any address outside it is an error.
REQ-003 Byte order SHALL be little-endian: offset 0 = bits [7:0], offset 3 = bits [31:24]; a half at offset 2 = bits [31:16].
REQ-004 States SHALL be IDLE, READ, WRITE, RESP; the state is registered.
REQ-005 In IDLE, req_valid && req_ready at a rising edge SHALL latch req_we, req_size, req_signed, req_addr and req_wdata; the acceptance cycle is cycle 0.
REQ-006 On accept, any of the following SHALL be an error and go to RESP with resp_err = 1:
- req_size = 11;
- half with addr[0] = 1;
- word with addr[1:0] != 00;
- out-of-window address.
REQ-007 On accept, a valid load or a byte/half store SHALL go to READ; a valid word store SHALL go to WRITE.
REQ-008 READ SHALL drive mem_addr = {addr[31:2], 2'b00} and mem_we = 0, and capture mem_rdata at the closing edge.
- Load: extract the selected byte/half/word, extend per req_signed, go to RESP.
- Sub-word store: merge req_wdata[7:0] or [15:0] into the captured word at the offset, go to WRITE.
REQ-009 WRITE SHALL assert mem_we = 1 for exactly one cycle, with mem_addr aligned and mem_wdata = the merged word (or req_wdata for a word store), then go to RESP with resp_rdata = 0.
REQ-010 RESP SHALL hold resp_valid = 1 with resp_rdata and resp_err stable until resp_ready = 1 at a rising edge, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-011 Latency from accept to first resp_valid cycle SHALL be:
- error: cycle 1;
- load or word store: cycle 2;
- sub-word store: cycle 3.
REQ-012 mem_we SHALL be 0 in every state except WRITE; error requests SHALL generate no memory access and no mem_we pulse.
REQ-013 req_valid SHALL be ignored outside IDLE, and request inputs SHALL be ignored after acceptance.
REQ-014 Word loads SHALL ignore req_signed.

Reset
REQ-015 While rst_n = 0, the block SHALL immediately (asynchronously) enter IDLE and drive:
- req_ready = 0, resp_valid = 0, resp_err = 0, mem_we = 0;
- resp_rdata = 0, mem_addr = 0, mem_wdata = 0.
REQ-016 req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-017 Reset mid-operation SHALL discard the in-flight request with no memory write; reset during WRITE SHALL force mem_we low before the next edge.

Verification
REQ-018 The bench SHALL cover these directed scenarios; for each, memory word 0x3FFC preloaded with 0x8899AABB:
- Signed byte load at 0x3FFD -> resp_rdata = 0xFFFFFFAA, resp_err = 0, resp_valid in cycle 2; unsigned -> 0x000000AA.
- Half store 0x00001234 at 0x3FFE -> one mem_we pulse in cycle 2, mem_addr = 0x3FFC, mem_wdata = 0x1234AABB; resp_valid in cycle 3, resp_rdata = 0.
- Word load at 0x3FFA -> resp_err = 1, resp_rdata = 0, resp_valid in cycle 1, no mem_we.
- Word store at 0x4000 -> resp_err = 1, memory unchanged.
- Load with resp_ready held low for 5 cycles -> resp_valid and resp_rdata constant, req_ready = 0 throughout, IDLE one cycle after the handshake.
- rst_n pulsed low during WRITE of a byte store -> mem_we drops immediately, 0x3FFC still 0x8899AABB, req_ready = 1 the first cycle after release.
